// File: rtl/pong_pkg.sv
// Shared constants and types for the key event generator: FSM encoding,
// key channel indices and default timing values.
package pong_pkg;

    localparam int unsigned NUM_KEYS = 4;

    localparam int unsigned KEY_UP   = 0;
    localparam int unsigned KEY_DOWN = 1;
    localparam int unsigned KEY_PLAY = 2;
    localparam int unsigned KEY_MENU = 3;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_RATE     = 5000000;
    localparam logic [NUM_KEYS-1:0] DEF_REPEAT_MASK = 4'b0011;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } key_state_t;

    // Counter width: enough bits for the largest timing value plus one spare.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return unsigned'($clog2(m)) + 1;
    endfunction

endpackage

// File: rtl/key_event_generator_if.sv
// Key bundle: raw active-low buttons in, debounced levels and event pulses out.
interface key_event_generator_if;
    import pong_pkg::*;

    logic [NUM_KEYS-1:0] keyN;
    logic [NUM_KEYS-1:0] keyLevel;
    logic [NUM_KEYS-1:0] keyPress;
    logic [NUM_KEYS-1:0] keyRelease;
    logic [NUM_KEYS-1:0] keyRepeat;

    modport master (
        output keyN,
        input  keyLevel,
        input  keyPress,
        input  keyRelease,
        input  keyRepeat
    );

    modport slave (
        input  keyN,
        output keyLevel,
        output keyPress,
        output keyRelease,
        output keyRepeat
    );

endinterface

// File: rtl/key_channel.sv
// One push-button channel: synchroniser, debounce FSM and auto-repeat timer.
module key_channel
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    logic          sync_q1;
    logic          sync_q2;
    key_state_t    state_q;
    key_state_t    state_d;
    logic [CW-1:0] deb_cnt_q;
    logic [CW-1:0] deb_cnt_d;
    logic [CW-1:0] rep_cnt_q;
    logic [CW-1:0] rep_cnt_d;
    logic          rep_first_q;
    logic          rep_first_d;
    logic          lvl_now;
    logic          lvl_next;
    logic          press_d;
    logic          release_d;
    logic          repeat_d;

    // Two-flop synchroniser; the inversion puts 1 = pressed and resets to released
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= ~key_n;
            sync_q2 <= sync_q1;
        end
    end

    // Next-state, debounce counter, repeat timer and pulse decode
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        repeat_d    = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                if (sync_q2) begin
                    state_d   = ST_DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!sync_q2) begin
                    state_d = ST_RELEASED;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d = ST_PRESSED;
                end else if (deb_cnt_q != CNT_MAX) begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!sync_q2) begin
                    state_d   = ST_DEB_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            ST_DEB_RELEASE: begin
                if (sync_q2) begin
                    state_d = ST_PRESSED;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d = ST_RELEASED;
                end else if (deb_cnt_q != CNT_MAX) begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = ST_RELEASED;
                deb_cnt_d = '0;
            end
        endcase

        lvl_now   = (state_q == ST_PRESSED) || (state_q == ST_DEB_RELEASE);
        lvl_next  = (state_d == ST_PRESSED) || (state_d == ST_DEB_RELEASE);
        press_d   = !lvl_now && lvl_next;
        release_d = lvl_now && !lvl_next;

        // Timer restarts on press, runs through release bounces, clears on release
        if (REPEAT_EN && lvl_next) begin
            if (press_d) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else if (rep_cnt_q >= (rep_first_q ? DELAY_LAST : RATE_LAST)) begin
                repeat_d    = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else if (rep_cnt_q != CNT_MAX) begin
                rep_cnt_d = rep_cnt_q + CW'(1);
            end
        end else begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RELEASED;
            deb_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            key_level   <= lvl_next;
            key_press   <= press_d;
            key_release <= release_d;
            key_repeat  <= repeat_d;
        end
    end

endmodule

// File: rtl/key_event_generator.sv
// Four independent debounced push-button channels with press/release/repeat events.
module key_event_generator
    import pong_pkg::*;
#(
    parameter int unsigned         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned         REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned         REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
    input  logic                  clock,
    input  logic                  reset,
    key_event_generator_if.slave  keys
);

    logic [NUM_KEYS-1:0] level_w;
    logic [NUM_KEYS-1:0] press_w;
    logic [NUM_KEYS-1:0] release_w;
    logic [NUM_KEYS-1:0] repeat_w;

    // One channel per key; no arbitration between channels
    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .key_n       (keys.keyN[i]),
            .key_level   (level_w[i]),
            .key_press   (press_w[i]),
            .key_release (release_w[i]),
            .key_repeat  (repeat_w[i])
        );
    end

    assign keys.keyLevel   = level_w;
    assign keys.keyPress   = press_w;
    assign keys.keyRelease = release_w;
    assign keys.keyRepeat  = repeat_w;

endmodule

// File: tb/tb_key_event_generator.sv
// Directed bench for key_event_generator with short timing values.
module tb_key_event_generator;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [3:0] exp_rep;

    key_event_generator_if kif();

    key_event_generator #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .REPEAT_MASK     (4'b0011)
    ) dut (
        .clock (clock),
        .reset (reset),
        .keys  (kif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   kif.keyLevel,   4'b0000);
        chk({tag, "_press"},   kif.keyPress,   4'b0000);
        chk({tag, "_release"}, kif.keyRelease, 4'b0000);
        chk({tag, "_repeat"},  kif.keyRepeat,  4'b0000);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        kif.keyN = 4'hF;
        tick(3);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(2);
        chk_all_zero("idle");

        // Clean press on Play: level and one press pulse 7 edges later, never repeats
        kif.keyN = 4'b1011;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("play_pre_lvl_%0d", k), kif.keyLevel, 4'b0000);
            chk($sformatf("play_pre_prs_%0d", k), kif.keyPress, 4'b0000);
        end
        tick();
        chk("play_press", kif.keyPress, 4'b0100);
        chk("play_level", kif.keyLevel, 4'b0100);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("play_hold_prs_%0d", k), kif.keyPress,  4'b0000);
            chk($sformatf("play_hold_rep_%0d", k), kif.keyRepeat, 4'b0000);
            chk($sformatf("play_hold_lvl_%0d", k), kif.keyLevel,  4'b0100);
        end
        kif.keyN = 4'hF;
        tick(6);
        chk("play_rel_pre_lvl", kif.keyLevel, 4'b0100);
        tick();
        chk("play_release", kif.keyRelease, 4'b0100);
        chk("play_rel_lvl", kif.keyLevel, 4'b0000);
        tick();
        chk("play_release_once", kif.keyRelease, 4'b0000);
        tick(3);

        // Three-cycle glitch on Up: nothing happens
        kif.keyN = 4'b1110;
        tick(3);
        kif.keyN = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("glitch_lvl_%0d", k), kif.keyLevel, 4'b0000);
            chk($sformatf("glitch_prs_%0d", k), kif.keyPress, 4'b0000);
        end

        // Hold Up: repeats at +10, +13, ... +28 after the press
        kif.keyN = 4'b1110;
        tick(7);
        chk("up_press", kif.keyPress, 4'b0001);
        chk("up_press_no_rep", kif.keyRepeat, 4'b0000);
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_rep = (k >= 10 && ((k - 10) % 3) == 0) ? 4'b0001 : 4'b0000;
            chk($sformatf("up_rep_%0d", k), kif.keyRepeat, exp_rep);
            chk($sformatf("up_lvl_%0d", k), kif.keyLevel, 4'b0001);
            chk($sformatf("up_prs_%0d", k), kif.keyPress, 4'b0000);
        end
        kif.keyN = 4'hF;
        for (int k = 31; k <= 36; k++) begin
            tick();
            chk($sformatf("up_relwin_lvl_%0d", k), kif.keyLevel,   4'b0001);
            chk($sformatf("up_relwin_rel_%0d", k), kif.keyRelease, 4'b0000);
        end
        tick();
        chk("up_release", kif.keyRelease, 4'b0001);
        chk("up_rel_lvl", kif.keyLevel,   4'b0000);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("up_after_rep_%0d", k), kif.keyRepeat,  4'b0000);
            chk($sformatf("up_after_rel_%0d", k), kif.keyRelease, 4'b0000);
        end

        // Down with a two-cycle bounce while held: level and cadence unbroken
        kif.keyN = 4'b1101;
        tick(7);
        chk("down_press", kif.keyPress, 4'b0010);
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) kif.keyN = 4'hF;
            tick();
            if (k == 6) kif.keyN = 4'b1101;
            exp_rep = (k >= 10 && ((k - 10) % 3) == 0) ? 4'b0010 : 4'b0000;
            chk($sformatf("bounce_lvl_%0d", k), kif.keyLevel,   4'b0010);
            chk($sformatf("bounce_prs_%0d", k), kif.keyPress,   4'b0000);
            chk($sformatf("bounce_rel_%0d", k), kif.keyRelease, 4'b0000);
            chk($sformatf("bounce_rep_%0d", k), kif.keyRepeat,  exp_rep);
        end
        kif.keyN = 4'hF;
        tick(7);
        chk("down_release", kif.keyRelease, 4'b0010);
        chk("down_rel_lvl", kif.keyLevel,   4'b0000);
        tick(5);

        // Menu and Up together: presses land on the same cycle
        kif.keyN = 4'b0110;
        tick(6);
        chk("simul_pre_prs", kif.keyPress, 4'b0000);
        tick();
        chk("simul_press", kif.keyPress, 4'b1001);
        chk("simul_level", kif.keyLevel, 4'b1001);
        kif.keyN = 4'hF;
        tick(7);
        chk("simul_release", kif.keyRelease, 4'b1001);
        chk("simul_rel_lvl", kif.keyLevel,   4'b0000);
        tick(5);

        // Reset while Down is held: silent, then a fresh press after full latency
        kif.keyN = 4'b1101;
        tick(7);
        chk("rst_down_press", kif.keyPress, 4'b0010);
        tick(3);
        reset = 1'b1;
        tick();
        chk_all_zero("rst_mid");
        tick(2);
        chk_all_zero("rst_hold");
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("rst_post_lvl_%0d", k), kif.keyLevel,   4'b0000);
            chk($sformatf("rst_post_rel_%0d", k), kif.keyRelease, 4'b0000);
            chk($sformatf("rst_post_prs_%0d", k), kif.keyPress,   4'b0000);
        end
        tick();
        chk("rst_repress", kif.keyPress, 4'b0010);
        chk("rst_relevel", kif.keyLevel, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_generator.md
KEY_EVENT_GENERATOR -- requirements
Module: key_event_generator

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles (10 ms at 50 MHz) before a level change is accepted.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000: cycles from keyPress to the first keyRepeat.
REQ-003 SHALL have parameter REPEAT_RATE, default 5000000: cycles between subsequent keyRepeat pulses.
REQ-004 SHALL have parameter REPEAT_MASK, default 4'b0011: channels with auto-repeat enabled (key0 Up, key1 Down).
REQ-005 SHALL have port clock, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port keyN, input, 4 bits: raw asynchronous push-buttons, active-low (bit0=Up, bit1=Down, bit2=Play, bit3=Menu).
REQ-008 SHALL have port keyLevel, output, 4 bits: debounced level, active-high (1 = pressed).
REQ-009 SHALL have port keyPress, output, 4 bits: one-cycle pulse per accepted press.
REQ-010 SHALL have port keyRelease, output, 4 bits: one-cycle pulse per accepted release.
REQ-011 SHALL have port keyRepeat, output, 4 bits: one-cycle auto-repeat pulse while held; masked channels only.

Function
REQ-012 Each keyN bit SHALL pass through a two-flop synchroniser and be inverted; only the synchronised value drives logic.
REQ-013 Each channel SHALL run an independent FSM with states RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE.
REQ-014 In RELEASED, synced=1 SHALL move the FSM to DEB_PRESS with the debounce counter cleared.
REQ-015 In DEB_PRESS, synced=0 SHALL return the FSM to RELEASED; after DEBOUNCE_CYCLES consecutive synced=1 cycles it SHALL enter PRESSED.
REQ-016 In PRESSED, synced=0 SHALL move the FSM to DEB_RELEASE with the counter cleared.
REQ-017 In DEB_RELEASE, synced=1 SHALL return the FSM to PRESSED without a new keyPress, and the repeat timer SHALL continue; after DEBOUNCE_CYCLES consecutive synced=0 cycles it SHALL enter RELEASED.
REQ-018 keyLevel SHALL be 1 in PRESSED and DEB_RELEASE, and 0 otherwise.
REQ-019 keyPress SHALL assert for exactly the one cycle in which keyLevel first reads 1; keyRelease SHALL assert for exactly the one cycle in which keyLevel first reads 0.
REQ-020 Latency: with a stable input, keyLevel SHALL change DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new keyN value.
REQ-021 Repeat, masked channel only: a timer SHALL start at keyPress; keyRepeat SHALL pulse REPEAT_DELAY cycles after keyPress, then every REPEAT_RATE cycles while keyLevel=1.
REQ-022 keyRepeat SHALL never coincide with keyPress; the repeat timer SHALL clear at keyRelease.
REQ-023 Unmasked channels SHALL hold keyRepeat at 0 permanently.
REQ-024 Counters SHALL saturate and never wrap; counter width SHALL be $clog2 of the largest parameter plus 1.
REQ-025 Simultaneous events on different channels SHALL be processed independently in the same cycle; there SHALL be no priority or arbitration.
REQ-026 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no change on keyLevel.

Reset
REQ-027 While reset=1: every FSM SHALL be in RELEASED, all counters 0, synchroniser flops 0 (i.e. released), and all outputs 0.
REQ-028 Reset mid-press SHALL produce no keyRelease pulse; a key still held after reset deasserts SHALL produce a fresh keyPress after the full debounce latency.

Structure
REQ-029 The shared package pong_pkg SHALL hold the FSM state encoding, the key index constants (KEY_UP=0, KEY_DOWN=1, KEY_PLAY=2, KEY_MENU=3) and the default timing constants.
REQ-030 The per-channel logic (synchroniser, FSM, debounce counter, repeat timer) SHALL be one sub-module, key_channel, instantiated four times by a generate loop; the repeat-enable bit is passed to each instance as a parameter.

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
REQ-031 Clean press: keyN[2] 1->0 and held -> keyLevel[2]=1 and a single keyPress[2] pulse 7 edges later; keyRepeat[2] stays 0.
REQ-032 Glitch: keyN[0] low for 3 cycles -> no pulses; keyLevel[0] stays 0.
REQ-033 Hold Up for 30 cycles after keyPress -> keyRepeat[0] pulses at +10, +13, +16, ... +28; release -> one keyRelease[0] pulse and no further keyRepeat.
REQ-034 Bounce during release: keyN[1] high for 2 cycles, then low -> keyLevel[1] stays 1 with no keyRelease or second keyPress, and the repeat cadence is unbroken.
REQ-035 Simultaneous press: keyN[3] and keyN[0] fall on the same edge -> keyPress[3] and keyPress[0] assert on the same cycle.
REQ-036 Reset while Down is held -> all outputs 0 with no keyRelease; after reset deasserts with the key still held -> keyPress[1] 7 edges later.
